pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the 2-bit NextType decision from the branch/jump detect stage.
- Owns the architectural PC register and applies redirects for predicted-taken branches (decided in ID), mispredict recovery (EX), and jumps.
- Drives IF/ID and ID/EX flush strobes and the fetch PC.
- Keeps saturating performance counters for resolved branches and mispredicts.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- next_type  in  2  from branch/jump detect: 00 PLUS4, 01 PREDICT_RIGHT, 10 PREDICT_WRONG, 11 JUMP.
- ex_valid  in  1  EX-stage instruction is real (not a bubble); qualifies next_type.
- recover_pc  in  32  ID/EX PC+4; fall-through address used on PREDICT_WRONG.
- jump_pc  in  32  jump target resolved in EX.
- id_branch  in  1  ID holds a conditional branch; predict taken.
- id_branch_target  in  32  branch target computed in ID.
- stall  in  1  load-use hazard stall from the hazard unit.
- pc  out  32  current fetch PC (registered).
- flush_ifid  out  1  squash the IF/ID register at the next edge.
- flush_idex  out  1  squash the ID/EX register at the next edge.
- redirect_busy  out  1  high while in the REDIRECT state.
- branch_cnt  out  CNT_W  resolved branches (PREDICT_RIGHT + PREDICT_WRONG).
- mispredict_cnt  out  CNT_W  PREDICT_WRONG events.

Behaviour:
- Reset (synchronous): pc=RESET_PC, state=RUN, both counters=0. flush_ifid, flush_idex and redirect_busy read 0 while rst=1.
- Event classification is valid only when ex_valid=1 and state!=REDIRECT. Otherwise next_type is treated as PLUS4 and the counters do not change.
- Priority (highest first), evaluated each cycle:
  - (1) rst.
  - (2) PREDICT_WRONG: pc<=recover_pc; flush_ifid=1, flush_idex=1; state<=REDIRECT.
  - (3) JUMP: pc<=jump_pc; flush_ifid=1, flush_idex=1; state<=REDIRECT.
  - (4) stall: pc holds; no flush; state<=STALL.
  - (5) id_branch: pc<=id_branch_target; flush_ifid=1.
  - (6) Otherwise: pc<=pc+4, wrapping modulo 2^32.
- PREDICT_RIGHT updates only branch_cnt; pc follows rules 4–6.
- Flush outputs are combinational from the current inputs and state, so they take effect at the same edge that loads the new pc. Redirect latency is 1 cycle; the instruction at the new pc is fetched in the following cycle.
- States:
  - RUN: normal operation.
  - STALL: entered on stall; pc holds while stall=1. Returns to RUN on the first cycle with stall=0, applying rules 5/6 in that cycle. A redirect (rule 2 or 3) overrides STALL immediately.
  - REDIRECT: exactly 1 cycle. EX holds a squashed wrong-path slot, so next_type is ignored and stall is ignored. id_branch is honoured (rule 5), else pc+4. Always returns to RUN.
- redirect_busy=1 exactly when state=REDIRECT.
- Counters:
  - branch_cnt +1 on each qualified PREDICT_RIGHT or PREDICT_WRONG.
  - mispredict_cnt +1 on each qualified PREDICT_WRONG.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Invariants:
  - pc[1:0] is always 00. A redirect target with nonzero low bits is masked to 00.
  - flush_idex=1 implies flush_ifid=1.
- Reset mid-redirect or mid-stall: the next cycle is RUN at RESET_PC, with no residual flush.

Test Plan:
- Reset then 3 idle cycles (ex_valid=0) -> pc=0x3000, 0x3004, 0x3008; flushes 0; counters 0.
- pc=0x3010, id_branch=1, target=0x3040 -> next pc=0x3040, flush_ifid=1, flush_idex=0; next cycle ex_valid=1, next_type=01 -> branch_cnt=1, mispredict_cnt=0, pc=0x3044.
- ex_valid=1, next_type=10, recover_pc=0x3014, with stall=1 and id_branch=1 in the same cycle -> pc=0x3014, both flushes 1, redirect_busy=1 next cycle; a next_type=10 presented during REDIRECT is ignored; mispredict_cnt=1.
- stall=1 for 3 cycles at pc=0x3020 -> pc holds 0x3020; stall drops -> 0x3024; next_type=11, jump_pc=0x3100 during stall -> pc=0x3100 immediately.
- Preload mispredict_cnt=2^CNT_W-1 (CNT_W=4 build) and issue 2 PREDICT_WRONG -> mispredict_cnt stays 15.
- Assert rst while in REDIRECT with pc=0x3100 -> next cycle pc=0x3000, state RUN, counters 0, redirect_busy=0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// ============================================================================
//  Module   : pc_redirect_unit
//  Purpose  : Fetch PC owner; applies predicted-taken, mispredict and jump
//             redirects, drives pipeline flushes, counts branch outcomes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       next_type,
  input  logic             ex_valid,
  input  logic [31:0]      recover_pc,
  input  logic [31:0]      jump_pc,
  input  logic             id_branch,
  input  logic [31:0]      id_branch_target,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [1:0] c_NT_PLUS4 = 2'b00;
  localparam logic [1:0] c_NT_RIGHT = 2'b01;
  localparam logic [1:0] c_NT_WRONG = 2'b10;
  localparam logic [1:0] c_NT_JUMP  = 2'b11;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_STALL    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;
  logic             w_qualified;
  logic [1:0]       w_event;
  logic             w_flush_ifid, w_flush_idex;
  logic             w_br_inc, w_mp_inc;

  // The EX slot behind a redirect is a squashed wrong-path instruction.
  assign w_qualified = ex_valid && (state_q != S_REDIRECT);
  assign w_event     = w_qualified ? next_type : c_NT_PLUS4;

  always_comb begin
    state_d      = S_RUN;
    pc_d         = pc_q + 32'd4;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_br_inc     = 1'b0;
    w_mp_inc     = 1'b0;

    if (w_event == c_NT_WRONG) begin
      pc_d         = recover_pc;
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
      state_d      = S_REDIRECT;
      w_br_inc     = 1'b1;
      w_mp_inc     = 1'b1;
    end else if (w_event == c_NT_JUMP) begin
      pc_d         = jump_pc;
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
      state_d      = S_REDIRECT;
    end else begin
      w_br_inc = (w_event == c_NT_RIGHT);
      if (stall && (state_q != S_REDIRECT)) begin
        pc_d    = pc_q;
        state_d = S_STALL;
      end else if (id_branch) begin
        pc_d         = id_branch_target;
        w_flush_ifid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= {RESET_PC[31:2], 2'b00};
      state_q          <= S_RUN;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q    <= {pc_d[31:2], 2'b00};
      state_q <= state_d;
      if (w_br_inc && (branch_cnt_q != {CNT_W{1'b1}}))
        branch_cnt_q <= branch_cnt_q + 1'b1;
      if (w_mp_inc && (mispredict_cnt_q != {CNT_W{1'b1}}))
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end

  // Strobes are suppressed during reset so nothing is squashed on the way out.
  assign flush_ifid     = w_flush_ifid && !rst;
  assign flush_idex     = w_flush_idex && !rst;
  assign redirect_busy  = (state_q == S_REDIRECT) && !rst;
  assign pc             = pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
//  Module   : tb_pc_redirect_unit
//  Purpose  : Directed and randomized self-checking bench for pc_redirect_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

  localparam int          CNT_W   = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       next_type;
  logic             ex_valid;
  logic [31:0]      recover_pc;
  logic [31:0]      jump_pc;
  logic             id_branch;
  logic [31:0]      id_branch_target;
  logic             stall;
  logic [31:0]      pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             redirect_busy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .next_type        (next_type),
    .ex_valid         (ex_valid),
    .recover_pc       (recover_pc),
    .jump_pc          (jump_pc),
    .id_branch        (id_branch),
    .id_branch_target (id_branch_target),
    .stall            (stall),
    .pc               (pc),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .redirect_busy    (redirect_busy),
    .branch_cnt       (branch_cnt),
    .mispredict_cnt   (mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: architectural PC, a one-shot "previous cycle redirected"
  // flag, and unbounded event tallies that are clipped when compared.
  logic [31:0] m_pc;
  bit          m_after_redirect;
  int          m_branches;
  int          m_mispredicts;
  bit          m_valid = 1'b0;

  function automatic int clip(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic model_step(output logic [31:0] npc, output bit fi,
                            output bit fe, output bit redir,
                            output bit is_branch, output bit is_wrong);
    bit live, wrong, jmp, hold, take;
    live      = ex_valid && !m_after_redirect;
    wrong     = live && (next_type == 2'd2);
    jmp       = live && (next_type == 2'd3);
    hold      = !wrong && !jmp && stall && !m_after_redirect;
    take      = !wrong && !jmp && !hold && id_branch;
    if (wrong)      npc = recover_pc;
    else if (jmp)   npc = jump_pc;
    else if (hold)  npc = m_pc;
    else if (take)  npc = id_branch_target;
    else            npc = m_pc + 32'd4;
    npc       = npc & 32'hFFFF_FFFC;
    redir     = wrong || jmp;
    fi        = !rst && (redir || take);
    fe        = !rst && redir;
    is_branch = live && (next_type == 2'd1 || next_type == 2'd2);
    is_wrong  = wrong;
  endtask

  always @(posedge clk) begin
    logic [31:0] npc;
    bit fi, fe, redir, isb, isw;
    if (rst) begin
      m_pc             = RST_PC;
      m_after_redirect = 1'b0;
      m_branches       = 0;
      m_mispredicts    = 0;
      m_valid          = 1'b1;
    end else if (m_valid) begin
      model_step(npc, fi, fe, redir, isb, isw);
      m_pc             = npc;
      m_after_redirect = redir;
      m_branches       = m_branches + int'(isb);
      m_mispredicts    = m_mispredicts + int'(isw);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] npc;
    bit fi, fe, redir, isb, isw;
    if (m_valid) begin
      model_step(npc, fi, fe, redir, isb, isw);
      check("model pc",         pc,                    m_pc);
      check("model flush_ifid", 32'(flush_ifid),       32'(fi));
      check("model flush_idex", 32'(flush_idex),       32'(fe));
      check("model busy",       32'(redirect_busy),    32'(m_after_redirect && !rst));
      check("model branch_cnt", 32'(branch_cnt),       32'(clip(m_branches)));
      check("model mispred",    32'(mispredict_cnt),   32'(clip(m_mispredicts)));
      check("pc aligned",       32'(pc[1:0]),          32'd0);
      check("idex implies ifid", 32'(flush_idex && !flush_ifid), 32'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ex_valid = 1'b0; next_type = 2'd0; stall = 1'b0; id_branch = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    recover_pc = 32'h0; jump_pc = 32'h0; id_branch_target = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("reset pc", pc, 32'h3000);
    check("reset br", 32'(branch_cnt), 32'd0);
    check("reset mp", 32'(mispredict_cnt), 32'd0);
    check("reset flush", 32'(flush_ifid | flush_idex), 32'd0);
    tick(); check("idle pc1", pc, 32'h3004);
    tick(); check("idle pc2", pc, 32'h3008);
    tick(); tick(); check("pc 3010", pc, 32'h3010);

    id_branch = 1'b1; id_branch_target = 32'h3040; #1;
    check("bt flush_ifid", 32'(flush_ifid), 32'd1);
    check("bt flush_idex", 32'(flush_idex), 32'd0);
    tick(); check("bt pc", pc, 32'h3040);
    id_branch = 1'b0; ex_valid = 1'b1; next_type = 2'd1;
    tick();
    check("right pc", pc, 32'h3044);
    check("right br", 32'(branch_cnt), 32'd1);
    check("right mp", 32'(mispredict_cnt), 32'd0);

    next_type = 2'd2; recover_pc = 32'h3014; stall = 1'b1;
    id_branch = 1'b1; id_branch_target = 32'h3080; #1;
    check("wrong both flush", 32'({flush_ifid, flush_idex}), 32'd3);
    tick();
    check("wrong pc", pc, 32'h3014);
    check("wrong busy", 32'(redirect_busy), 32'd1);
    check("wrong mp", 32'(mispredict_cnt), 32'd1);
    id_branch = 1'b0; #1;
    check("redir ignores nt", 32'(flush_idex), 32'd0);
    tick();
    check("redir ignores stall", pc, 32'h3018);
    check("redir mp held", 32'(mispredict_cnt), 32'd1);
    check("redir busy gone", 32'(redirect_busy), 32'd0);

    idle(); tick(); tick(); check("pc 3020", pc, 32'h3020);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check("stall hold", pc, 32'h3020); end
    stall = 1'b0; tick(); check("stall release", pc, 32'h3024);
    stall = 1'b1; tick(); check("stall again", pc, 32'h3024);
    ex_valid = 1'b1; next_type = 2'd3; jump_pc = 32'h3100; tick();
    check("jump over stall", pc, 32'h3100);
    check("jump busy", 32'(redirect_busy), 32'd1);

    rst = 1'b1; next_type = 2'd2; #1;
    check("rst busy low", 32'(redirect_busy), 32'd0);
    check("rst flush low", 32'({flush_ifid, flush_idex}), 32'd0);
    tick(); rst = 1'b0; idle();
    check("rst pc", pc, 32'h3000);
    check("rst busy", 32'(redirect_busy), 32'd0);
    check("rst mp", 32'(mispredict_cnt), 32'd0);

    ex_valid = 1'b1; next_type = 2'd2; recover_pc = 32'h3007; tick();
    check("masked target", pc, 32'h3004);
    for (int i = 0; i < 40; i++) tick();
    check("sat mp", 32'(mispredict_cnt), 32'd15);
    check("sat br", 32'(branch_cnt), 32'd15);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 63) == 0);
      ex_valid         = $urandom_range(0, 3) != 0;
      next_type        = 2'($urandom_range(0, 3));
      stall            = ($urandom_range(0, 3) == 0);
      id_branch        = ($urandom_range(0, 3) == 0);
      recover_pc       = $urandom;
      jump_pc          = $urandom;
      id_branch_target = $urandom;
      tick();
    end
    rst = 1'b0; idle(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
